// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: access size codes, MEM-stage state encoding, bus error data.
// Combinational only (no latency, no backpressure).
package mips_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_BUSY = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_e;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

    // Reserved size 2'b11 is treated as a word access.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~lane[0];
            default: return (lane == 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and data memory (slave).
// req is held with stable addr/we/wdata/be until a one-cycle ack.
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering: store replication/byte enables and load extract/extend.
// Purely combinational; no latency, no backpressure.
module mem_lane_align
    import mips_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_lane,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_lane,
    input  logic        ld_sign,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] ld_shift;

    always_comb begin
        st_wdata = st_data;
        st_be    = 4'b1111;
        case (st_size)
            SZ_BYTE: begin
                st_wdata = {4{st_data[7:0]}};
                st_be    = 4'b0001 << st_lane;
            end
            SZ_HALF: begin
                st_wdata = {2{st_data[15:0]}};
                st_be    = 4'b0011 << st_lane;
            end
            default: ;
        endcase
    end

    // Bring the addressed lane down to bit 0 before extending.
    assign ld_shift = ld_rdata >> {ld_lane, 3'b000};

    always_comb begin
        ld_data = ld_rdata;
        case (ld_size)
            SZ_BYTE: ld_data = {{24{ld_sign & ld_shift[7]}}, ld_shift[7:0]};
            SZ_HALF: ld_data = {{16{ld_sign & ld_shift[15]}}, ld_shift[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: loads/stores over req/ack with lane steering, misalign check and ack timeout.
// Non-memory ops pass through in the same cycle; memory ops stall until ack/timeout, result shown in DONE (held by stall_in).
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        stall_in,
    input  logic        ex_inst_en,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rs,
    input  logic [4:0]  ex_rt,
    input  logic [4:0]  ex_rdst,
    input  logic        ex_regw,
    input  logic        ex_memr,
    input  logic        ex_memw,
    input  logic [1:0]  ex_size,
    input  logic        ex_sign,
    output logic [31:0] mem_alu_result,
    output logic [31:0] mem_mem_result,
    output logic [4:0]  mem_rs,
    output logic [4:0]  mem_rt,
    output logic [4:0]  mem_rdst,
    output logic        mem_regw,
    output logic        mem_memr,
    output logic        mem_memw,
    output logic        mem_inst_en,
    output logic        stall_out,
    output logic        misalign,
    output logic        bus_err,
    mem_access_stage_if.master dmem
);

    localparam logic [1:0] S_IDLE = MEM_IDLE;
    localparam logic [1:0] S_BUSY = MEM_BUSY;
    localparam logic [1:0] S_DONE = MEM_DONE;
    localparam int         CW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [1:0]    state;
    logic          req_q, we_q, squash_q, sign_q;
    logic [31:0]   addr_q, wdata_q, load_data;
    logic [3:0]    be_q;
    logic [1:0]    size_q, lane_q;
    logic [CW-1:0] cnt;

    logic          mem_op, aligned, access, kill, timeout_hit;
    logic [31:0]   st_wdata, ld_data;
    logic [3:0]    st_be;

    mem_lane_align u_lane (
        .st_size  (ex_size),
        .st_lane  (ex_alu_result[1:0]),
        .st_data  (ex_store_data),
        .st_wdata (st_wdata),
        .st_be    (st_be),
        .ld_size  (size_q),
        .ld_lane  (lane_q),
        .ld_sign  (sign_q),
        .ld_rdata (dmem.dmem_rdata),
        .ld_data  (ld_data)
    );

    assign mem_op      = ex_inst_en & (ex_memr | ex_memw);
    assign aligned     = is_aligned(ex_size, ex_alu_result[1:0]);
    assign misalign    = mem_op & ~aligned;
    assign access      = mem_op & aligned & ~flush;
    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            load_data <= '0;
            cnt       <= '0;
            bus_err   <= 1'b0;
            squash_q  <= 1'b0;
            size_q    <= '0;
            sign_q    <= 1'b0;
            lane_q    <= '0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (access) begin
                        req_q    <= 1'b1;
                        we_q     <= ex_memw;
                        addr_q   <= {ex_alu_result[31:2], 2'b00};
                        wdata_q  <= st_wdata;
                        be_q     <= st_be;
                        size_q   <= ex_size;
                        sign_q   <= ex_sign;
                        lane_q   <= ex_alu_result[1:0];
                        cnt      <= '0;
                        squash_q <= 1'b0;
                        state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    cnt <= cnt + 1'b1;
                    // A flush cannot abandon the handshake; remember it and drop the result later.
                    if (flush) squash_q <= 1'b1;
                    if (dmem.dmem_ack) begin
                        load_data <= we_q ? 32'h0 : ld_data;
                        req_q     <= 1'b0;
                        we_q      <= 1'b0;
                        state     <= S_DONE;
                    end else if (timeout_hit) begin
                        load_data <= ERR_DATA;
                        bus_err   <= 1'b1;
                        req_q     <= 1'b0;
                        we_q      <= 1'b0;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (flush) squash_q <= 1'b1;
                    if (!stall_in) begin
                        squash_q <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign kill = flush | squash_q;

    assign mem_alu_result = ex_alu_result;
    assign mem_mem_result = (state == S_DONE) ? load_data : 32'h0;
    assign mem_rs         = ex_rs;
    assign mem_rt         = ex_rt;
    assign mem_rdst       = ex_rdst;
    assign mem_inst_en    = ~rst & ex_inst_en & ~kill;
    assign mem_regw       = ~rst & ex_regw & ~kill & ~misalign;
    assign mem_memr       = ex_memr & ~misalign;
    assign mem_memw       = ex_memw & ~misalign;
    assign stall_out      = ~rst & (((state == S_IDLE) & access) | (state == S_BUSY));

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ack-delay memory responder plus an expected-result queue.
module tb_mem_access_stage;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, stall_in, ex_inst_en;
    logic [31:0] ex_alu_result, ex_store_data;
    logic [4:0]  ex_rs, ex_rt, ex_rdst;
    logic        ex_regw, ex_memr, ex_memw, ex_sign;
    logic [1:0]  ex_size;
    logic [31:0] mem_alu_result, mem_mem_result;
    logic [4:0]  mem_rs, mem_rt, mem_rdst;
    logic        mem_regw, mem_memr, mem_memw, mem_inst_en;
    logic        stall_out, misalign, bus_err;

    mem_access_stage_if bus ();

    mem_access_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .stall_in(stall_in),
        .ex_inst_en(ex_inst_en), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rdst(ex_rdst),
        .ex_regw(ex_regw), .ex_memr(ex_memr), .ex_memw(ex_memw),
        .ex_size(ex_size), .ex_sign(ex_sign),
        .mem_alu_result(mem_alu_result), .mem_mem_result(mem_mem_result),
        .mem_rs(mem_rs), .mem_rt(mem_rt), .mem_rdst(mem_rdst),
        .mem_regw(mem_regw), .mem_memr(mem_memr), .mem_memw(mem_memw), .mem_inst_en(mem_inst_en),
        .stall_out(stall_out), .misalign(misalign), .bus_err(bus_err),
        .dmem(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] mres;
        logic        inst_en;
        logic        regw;
        logic        memw;
        logic        misal;
        logic        err;
        int          stalls;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Memory responder: acks in the ack_at-th cycle of a request (0 = never).
    int          ack_at   = 0;
    int          req_cyc  = 0;
    logic [31:0] rsp_data = 32'h0;
    logic        stray_ack = 1'b0;

    initial begin
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus.dmem_rdata = rsp_data;
            if (bus.dmem_req) begin
                req_cyc++;
                bus.dmem_ack = (ack_at != 0) && (req_cyc == ack_at);
            end else begin
                req_cyc      = 0;
                bus.dmem_ack = stray_ack;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] mres, input logic inst_en, input logic regw,
                                input logic memw, input logic misal, input logic err, input int stalls);
        exp_t e;
        e.mres = mres; e.inst_en = inst_en; e.regw = regw; e.memw = memw;
        e.misal = misal; e.err = err; e.stalls = stalls;
        return e;
    endfunction

    task automatic do_op(input string tag, input logic [1:0] size, input logic sign,
                         input logic memr, input logic memw, input logic regw,
                         input logic [31:0] addr, input logic [31:0] sdata,
                         input int ack_n, input logic [31:0] rdata, input int flush_at, input int hold,
                         input logic [3:0] be_x, input logic [31:0] wd_x, input exp_t e_in);
        exp_t e;
        int   stalls;
        bit   done;
        @(posedge clk);
        #1;
        ex_inst_en = 1'b1; ex_size = size; ex_sign = sign;
        ex_memr = memr; ex_memw = memw; ex_regw = regw;
        ex_alu_result = addr; ex_store_data = sdata;
        ex_rs = 5'd3; ex_rt = 5'd4; ex_rdst = 5'd5;
        ack_at = ack_n; rsp_data = rdata; stall_in = (hold > 0);
        sb.push_back(e_in);
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            flush = (c == flush_at);
            @(negedge clk);
            if (!stall_out) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (c > 0) begin
                    chk({tag, ":req"},  32'(bus.dmem_req), 32'd1);
                    chk({tag, ":addr"}, bus.dmem_addr, {addr[31:2], 2'b00});
                    chk({tag, ":be"},   32'(bus.dmem_be), 32'(be_x));
                    chk({tag, ":we"},   32'(bus.dmem_we), 32'(memw));
                    if (memw) chk({tag, ":wdata"}, bus.dmem_wdata, wd_x);
                end
                @(posedge clk);
                #1;
            end
        end
        total++;
        assert (done) else begin
            bad++;
            $error("FAIL %s:release observed=stall_held expected=release_within_40", tag);
        end
        if (done) begin
            e = sb.pop_front();
            chk({tag, ":mres"},    mem_mem_result, e.mres);
            chk({tag, ":inst_en"}, 32'(mem_inst_en), 32'(e.inst_en));
            chk({tag, ":regw"},    32'(mem_regw), 32'(e.regw));
            chk({tag, ":memw"},    32'(mem_memw), 32'(e.memw));
            chk({tag, ":misal"},   32'(misalign), 32'(e.misal));
            chk({tag, ":bus_err"}, 32'(bus_err), 32'(e.err));
            chk({tag, ":stalls"},  32'(stalls), 32'(e.stalls));
            chk({tag, ":alu"},     mem_alu_result, addr);
            chk({tag, ":rdst"},    32'(mem_rdst), 32'd5);
            if (e.stalls == 0) chk({tag, ":noreq"}, 32'(bus.dmem_req), 32'd0);
            for (int h = 0; h < hold; h++) begin
                @(posedge clk);
                #1;
                if (h == hold - 1) stall_in = 1'b0;
                @(negedge clk);
                chk({tag, ":hold_mres"},  mem_mem_result, e.mres);
                chk({tag, ":hold_stall"}, 32'(stall_out), 32'd0);
            end
        end
        @(posedge clk);
        #1;
        ex_inst_en = 1'b0; ex_memr = 1'b0; ex_memw = 1'b0; ex_regw = 1'b0;
        flush = 1'b0; stall_in = 1'b0; stray_ack = 1'b0; ack_at = 0;
        @(negedge clk);
        chk({tag, ":idle_stall"}, 32'(stall_out), 32'd0);
        chk({tag, ":idle_req"},   32'(bus.dmem_req), 32'd0);
        chk({tag, ":idle_err"},   32'(bus_err), 32'd0);
        chk({tag, ":idle_mres"},  mem_mem_result, 32'h0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall_in = 1'b0;
        ex_inst_en = 1'b1; ex_alu_result = 32'h100; ex_store_data = 32'h0;
        ex_rs = 5'd1; ex_rt = 5'd2; ex_rdst = 5'd3;
        ex_regw = 1'b1; ex_memr = 1'b1; ex_memw = 1'b0; ex_size = SZ_WORD; ex_sign = 1'b0;

        // Reset state, with a would-be load on the inputs.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst:stall",   32'(stall_out), 32'd0);
        chk("rst:inst_en", 32'(mem_inst_en), 32'd0);
        chk("rst:regw",    32'(mem_regw), 32'd0);
        chk("rst:req",     32'(bus.dmem_req), 32'd0);
        chk("rst:be",      32'(bus.dmem_be), 32'd0);
        chk("rst:addr",    bus.dmem_addr, 32'h0);
        chk("rst:err",     32'(bus_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; ex_inst_en = 1'b0;

        stray_ack = 1'b1;
        do_op("alu", SZ_WORD, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234, 32'h0, 0, 32'h0, -1, 0,
              4'h0, 32'h0, mk(32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0));
        do_op("lw", SZ_WORD, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 3, 32'hCAFEF00D, -1, 0,
              4'hF, 32'h0, mk(32'hCAFEF00D, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4));
        do_op("lb", SZ_BYTE, 1'b1, 1'b1, 1'b0, 1'b1, 32'h103, 32'h0, 1, 32'h80123456, -1, 0,
              4'b1000, 32'h0, mk(32'hFFFFFF80, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2));
        stray_ack = 1'b1;
        do_op("lbu", SZ_BYTE, 1'b0, 1'b1, 1'b0, 1'b1, 32'h103, 32'h0, 1, 32'h80123456, -1, 0,
              4'b1000, 32'h0, mk(32'h00000080, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2));
        do_op("lh", SZ_HALF, 1'b1, 1'b1, 1'b0, 1'b1, 32'h102, 32'h0, 2, 32'h80011234, -1, 0,
              4'b1100, 32'h0, mk(32'hFFFF8001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3));
        do_op("lhu_hold", SZ_HALF, 1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 1, 32'h80011234, -1, 2,
              4'b0011, 32'h0, mk(32'h00001234, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2));
        do_op("sh", SZ_HALF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h102, 32'h0000ABCD, 2, 32'h0, -1, 0,
              4'b1100, 32'hABCDABCD, mk(32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3));
        do_op("sb", SZ_BYTE, 1'b0, 1'b0, 1'b1, 1'b0, 32'h101, 32'h1234565A, 1, 32'h0, -1, 0,
              4'b0010, 32'h5A5A5A5A, mk(32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2));
        do_op("sw", SZ_WORD, 1'b0, 1'b0, 1'b1, 1'b0, 32'h104, 32'h11223344, 1, 32'h0, -1, 0,
              4'hF, 32'h11223344, mk(32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2));
        do_op("sh_mis", SZ_HALF, 1'b0, 1'b0, 1'b1, 1'b0, 32'h101, 32'h0000ABCD, 1, 32'h0, -1, 0,
              4'h0, 32'h0, mk(32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0));
        do_op("lw_mis", SZ_WORD, 1'b0, 1'b1, 1'b0, 1'b1, 32'h102, 32'h0, 1, 32'h0, -1, 0,
              4'h0, 32'h0, mk(32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0));
        do_op("lw_tmo", SZ_WORD, 1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 0, 32'h12345678, -1, 0,
              4'hF, 32'h0, mk(32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 17));
        do_op("lw_last", SZ_WORD, 1'b0, 1'b1, 1'b0, 1'b1, 32'h204, 32'h0, 16, 32'h0BADF00D, -1, 0,
              4'hF, 32'h0, mk(32'h0BADF00D, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 17));
        do_op("sw_tmo", SZ_WORD, 1'b0, 1'b0, 1'b1, 1'b0, 32'h208, 32'hA5A5A5A5, 0, 32'h0, -1, 0,
              4'hF, 32'hA5A5A5A5, mk(32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 17));
        do_op("flush_busy", SZ_WORD, 1'b0, 1'b1, 1'b0, 1'b1, 32'h300, 32'h0, 4, 32'h55AA55AA, 2, 0,
              4'hF, 32'h0, mk(32'h55AA55AA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5));
        do_op("flush_idle", SZ_WORD, 1'b0, 1'b1, 1'b0, 1'b1, 32'h304, 32'h0, 1, 32'h0, 0, 0,
              4'hF, 32'h0, mk(32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0));

        // Reset in the middle of a load that never gets an ack.
        @(posedge clk);
        #1;
        ex_inst_en = 1'b1; ex_memr = 1'b1; ex_regw = 1'b1; ex_size = SZ_WORD;
        ex_alu_result = 32'h500; ack_at = 0;
        @(negedge clk);
        chk("rstbusy:idle_stall", 32'(stall_out), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rstbusy:req", 32'(bus.dmem_req), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rstbusy:stall",   32'(stall_out), 32'd0);
        chk("rstbusy:inst_en", 32'(mem_inst_en), 32'd0);
        chk("rstbusy:regw",    32'(mem_regw), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; ex_inst_en = 1'b0; ex_memr = 1'b0; ex_regw = 1'b0;
        @(negedge clk);
        chk("rstbusy:req_after",   32'(bus.dmem_req), 32'd0);
        chk("rstbusy:stall_after", 32'(stall_out), 32'd0);
        chk("rstbusy:mres_after",  mem_mem_result, 32'h0);

        do_op("lw_after_rst", SZ_WORD, 1'b0, 1'b1, 1'b0, 1'b1, 32'h10C, 32'h0, 1, 32'h01020304, -1, 0,
              4'hF, 32'h0, mk(32'h01020304, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
